// File: rtl/mxint_block_requantizer.sv
// -----------------------------------------------------------------------------
// mxint_block_requantizer
//
// Converts a wide MxInt block (BLOCK_SIZE signed mantissas sharing one
// unsigned biased exponent) into a narrow MxInt block. The block is first
// normalised by the smallest redundant-sign-bit count found across its
// mantissas. The mantissas are then truncated (floor) to the output width.
// Finally the shared exponent is rebiased and saturated.
//
// Both sides encode value = m * 2**(e - BIAS - (MW-1)).
//
// Pipeline: two registered stages, one block per cycle when unstalled.
//   stage 1 : captures the block and its normalisation shift L
//   stage 2 : holds the requantised output block
//
// Ports
//   clk               clock
//   rst               synchronous active-high reset
//   mdata_in_0        input mantissas, element i at [i]
//   edata_in_0        input shared exponent
//   data_in_0_valid   input valid
//   data_in_0_ready   input ready (combinational)
//   mdata_out_0       output mantissas, element i at [i]
//   edata_out_0       output shared exponent
//   data_out_0_valid  output valid
//   data_out_0_ready  output ready
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. A producer holding valid keeps its data stable until the
// transfer happens. Each stage register loads when it is empty, or when its
// current contents leave in the same cycle. Blocks are never dropped or
// duplicated, and their order is preserved.
// -----------------------------------------------------------------------------
module mxint_block_requantizer #(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 5,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 4,
    parameter int BLOCK_SIZE             = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [BLOCK_SIZE-1:0][DATA_IN_0_PRECISION_0-1:0]     mdata_in_0,
    input  logic [DATA_IN_0_PRECISION_1-1:0]                     edata_in_0,
    input  logic                                                 data_in_0_valid,
    output logic                                                 data_in_0_ready,
    output logic [BLOCK_SIZE-1:0][DATA_OUT_0_PRECISION_0-1:0]    mdata_out_0,
    output logic [DATA_OUT_0_PRECISION_1-1:0]                    edata_out_0,
    output logic                                                 data_out_0_valid,
    input  logic                                                 data_out_0_ready
);

    localparam int MWI = DATA_IN_0_PRECISION_0;
    localparam int EWI = DATA_IN_0_PRECISION_1;
    localparam int MWO = DATA_OUT_0_PRECISION_0;
    localparam int EWO = DATA_OUT_0_PRECISION_1;

    localparam int BI = (1 << (EWI - 1)) - 1;
    localparam int BO = (1 << (EWO - 1)) - 1;

    // Width of the normalisation shift (holds 0..MWI-1).
    localparam int LW = $clog2(MWI);
    // Signed working width for the rebiased exponent.
    localparam int EW = ((EWI > EWO) ? EWI : EWO) + 2;
    // Mantissa narrowing amount.
    localparam int SH = MWI - MWO;

    localparam logic signed [EW-1:0] BIAS_DELTA = EW'(BO - BI);
    localparam logic signed [EW-1:0] E_MAX      = EW'((1 << EWO) - 1);

    localparam logic [MWO-1:0] SAT_POS = {1'b0, {(MWO-1){1'b1}}};
    localparam logic [MWO-1:0] SAT_NEG = {1'b1, {(MWO-1){1'b0}}};

    // -------------------------------------------------------------------------
    // Normalisation helpers
    // -------------------------------------------------------------------------

    // Number of bits directly below the MSB that equal the MSB. Zero and -1
    // both give MWI-1.
    function automatic logic [LW-1:0] redundant_sign_bits(input logic [MWI-1:0] m);
        logic [LW-1:0] n;
        logic          done;
        n    = '0;
        done = 1'b0;
        for (int k = MWI - 2; k >= 0; k--) begin
            if (!done && (m[k] == m[MWI-1])) begin
                n = n + LW'(1);
            end else begin
                done = 1'b1;
            end
        end
        return n;
    endfunction

    // Block-wide shift: the smallest redundant-sign count over all mantissas.
    // An all-zero mantissa has MWI-1, so it never limits the shift.
    function automatic logic [LW-1:0] block_shift(
        input logic [BLOCK_SIZE-1:0][MWI-1:0] m
    );
        logic [LW-1:0] l_min;
        logic [LW-1:0] rb;
        l_min = LW'(MWI - 1);
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rb = redundant_sign_bits(m[i]);
            if (rb < l_min) begin
                l_min = rb;
            end
        end
        return l_min;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake control
    // -------------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_ready;
    logic s1_load;
    logic s2_load;

    // Stage 2 can accept when it is empty or when its block leaves this cycle.
    assign s2_ready        = !s2_valid || data_out_0_ready;
    // Same as !s1_valid || !s2_valid || data_out_0_ready.
    assign data_in_0_ready = !s1_valid || s2_ready;
    assign s1_load         = data_in_0_valid && data_in_0_ready;
    assign s2_load         = s1_valid && s2_ready;

    // -------------------------------------------------------------------------
    // Stage 1: capture block and its normalisation shift
    // -------------------------------------------------------------------------
    logic [BLOCK_SIZE-1:0][MWI-1:0] s1_m;
    logic [EWI-1:0]                 s1_e;
    logic [LW-1:0]                  s1_l;
    logic [LW-1:0]                  l_in;

    always_comb begin
        l_in = block_shift(mdata_in_0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_m     <= '0;
            s1_e     <= '0;
            s1_l     <= '0;
        end else begin
            // When the slot is free or draining, it takes whatever is offered.
            if (data_in_0_ready) begin
                s1_valid <= data_in_0_valid;
            end
            if (s1_load) begin
                s1_m <= mdata_in_0;
                s1_e <= edata_in_0;
                s1_l <= l_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 datapath: shift, truncate, rebias, saturate
    // -------------------------------------------------------------------------
    logic                           all_zero;
    logic signed [EW-1:0]           exp_calc;
    logic                           underflow;
    logic                           overflow;
    logic [BLOCK_SIZE-1:0][MWO-1:0] m_trunc;
    logic [BLOCK_SIZE-1:0][MWO-1:0] m_next;
    logic [EWO-1:0]                 e_next;

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (s1_m[i] != '0) begin
                all_zero = 1'b0;
            end
        end

        // E = e - BI + BO - L, with e and L zero-extended into the signed width.
        exp_calc = $signed({{(EW-EWI){1'b0}}, s1_e})
                 + BIAS_DELTA
                 - $signed({{(EW-LW){1'b0}}, s1_l});

        underflow = exp_calc[EW-1];
        overflow  = (exp_calc > E_MAX);

        // Normalise, then drop the low SH bits. The arithmetic right shift
        // floors toward minus infinity, so no rounding is applied.
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            m_trunc[i] = MWO'(($signed(s1_m[i]) <<< s1_l) >>> SH);
        end

        m_next = m_trunc;
        e_next = exp_calc[EWO-1:0];

        if (all_zero || underflow) begin
            // Nothing representable: flush the whole block to zero.
            m_next = '0;
            e_next = '0;
        end else if (overflow) begin
            // Clamp the exponent and push every nonzero input toward full scale.
            e_next = '1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (s1_m[i] == '0) begin
                    m_next[i] = '0;
                end else if (s1_m[i][MWI-1]) begin
                    m_next[i] = SAT_NEG;
                end else begin
                    m_next[i] = SAT_POS;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 register (output slot)
    // -------------------------------------------------------------------------
    logic [BLOCK_SIZE-1:0][MWO-1:0] s2_m;
    logic [EWO-1:0]                 s2_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_m     <= '0;
            s2_e     <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            // Loads only with a real block, so a held output never changes.
            if (s2_load) begin
                s2_m <= m_next;
                s2_e <= e_next;
            end
        end
    end

    assign mdata_out_0      = s2_m;
    assign edata_out_0      = s2_e;
    assign data_out_0_valid = s2_valid;

endmodule

// File: tb/tb_mxint_block_requantizer.sv
// -----------------------------------------------------------------------------
// tb_mxint_block_requantizer
//
// Self-checking bench for mxint_block_requantizer with default parameters.
// The stimulus driver pushes the expected output block for each accepted
// input. A monitor pops the expected block and compares it whenever an output
// transfer happens. The expected blocks come either from hand-derived
// constants or from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mxint_block_requantizer;

    localparam int MWI = 16;
    localparam int EWI = 5;
    localparam int MWO = 8;
    localparam int EWO = 4;
    localparam int BS  = 4;
    localparam int BI  = 15;
    localparam int BO  = 7;
    localparam int IW  = BS * MWI;
    localparam int OW  = BS * MWO + EWO;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUT
    logic [BS-1:0][MWI-1:0] mdata_in;
    logic [EWI-1:0]         edata_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [BS-1:0][MWO-1:0] mdata_out;
    logic [EWO-1:0]         edata_out;
    logic                   out_valid;
    logic                   out_ready;

    mxint_block_requantizer #(
        .DATA_IN_0_PRECISION_0  (MWI),
        .DATA_IN_0_PRECISION_1  (EWI),
        .DATA_OUT_0_PRECISION_0 (MWO),
        .DATA_OUT_0_PRECISION_1 (EWO),
        .BLOCK_SIZE             (BS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (mdata_in),
        .edata_in_0       (edata_in),
        .data_in_0_valid  (in_valid),
        .data_in_0_ready  (in_ready),
        .mdata_out_0      (mdata_out),
        .edata_out_0      (edata_out),
        .data_out_0_valid (out_valid),
        .data_out_0_ready (out_ready)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [OW-1:0] exp_q[$];
    int unsigned   cyc_q[$];
    int            errors    = 0;
    int            checks    = 0;
    int            out_count = 0;
    bit            lat_check = 1'b0;
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Arithmetic reference: the shift is the largest doubling count that keeps
    // every nonzero mantissa inside the signed input range. Truncation is
    // integer floor division.
    function automatic logic [OW-1:0] ref_model(input logic [IW-1:0] mf, input logic [EWI-1:0] ef);
        int v[BS];
        int l, s, ee, scaled, q, div, lo, hi;
        bit nz;
        logic [BS*MWO-1:0] mo;
        logic [EWO-1:0]    eo;
        lo  = -(1 << (MWI - 1));
        hi  = (1 << (MWI - 1)) - 1;
        div = 1 << (MWI - MWO);
        nz  = 1'b0;
        l   = MWI - 1;
        for (int i = 0; i < BS; i++) begin
            v[i] = int'($signed(mf[i*MWI +: MWI]));
            if (v[i] != 0) begin
                nz = 1'b1;
                s  = 0;
                while (s < MWI - 1 && v[i] * (1 << (s + 1)) >= lo && v[i] * (1 << (s + 1)) <= hi)
                    s++;
                if (s < l) l = s;
            end
        end
        ee = int'(ef) - BI + BO - l;
        mo = '0;
        eo = '0;
        if (nz && ee >= 0) begin
            if (ee > (1 << EWO) - 1) begin
                eo = EWO'((1 << EWO) - 1);
                for (int i = 0; i < BS; i++) begin
                    if (v[i] > 0)      mo[i*MWO +: MWO] = MWO'((1 << (MWO - 1)) - 1);
                    else if (v[i] < 0) mo[i*MWO +: MWO] = MWO'(-(1 << (MWO - 1)));
                end
            end else begin
                eo = EWO'(ee);
                for (int i = 0; i < BS; i++) begin
                    scaled = v[i] * (1 << l);
                    q = scaled / div;
                    if (scaled < 0 && (scaled % div) != 0) q = q - 1;
                    mo[i*MWO +: MWO] = MWO'(q);
                end
            end
        end
        return {mo, eo};
    endfunction

    // ---------------------------------------------------------------- monitor
    logic [OW-1:0] prev_data;
    bit            prev_stall = 1'b0;
    logic [OW-1:0] mon_exp;
    int unsigned   mon_cyc;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", OW'(out_valid), OW'(1));
                check("stall_data_held", {mdata_out, edata_out}, prev_data);
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no block", {mdata_out, edata_out});
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_cyc = cyc_q.pop_front();
                    check("block_data", {mdata_out, edata_out}, mon_exp);
                    if (lat_check) check("latency", OW'(cyc - mon_cyc), OW'(2));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = {mdata_out, edata_out};
        end
    end

    // ---------------------------------------------------------------- drivers
    // Called just after a rising edge. Returns just after the edge that
    // accepted the block, with valid dropped.
    task automatic send(input logic [IW-1:0] m, input logic [EWI-1:0] e, input logic [OW-1:0] expv);
        int  n;
        bit  done;
        n        = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        mdata_in = m;
        edata_in = e;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                cyc_q.push_back(cyc);
                done = 1'b1;
            end else if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL input_handshake_timeout: got ready=0, expected ready=1 within 500 cycles");
                done = 1'b1;
            end else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [MWI-1:0] rand_mant();
        logic [MWI-1:0] r;
        r = MWI'($urandom);
        case ($urandom_range(0, 4))
            0: return '0;
            1: return r;
            2: return MWI'($signed(r) >>> $urandom_range(1, MWI - 1));
            3: begin
                case ($urandom_range(0, 3))
                    0: return 16'h7FFF;
                    1: return 16'h8000;
                    2: return 16'hFFFF;
                    default: return 16'h0001;
                endcase
            end
            default: return MWI'($signed(r) >>> $urandom_range(6, MWI - 1));
        endcase
    endfunction

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 99) < 70);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main
    logic [IW-1:0]  m;
    logic [EWI-1:0] e;
    int             base;
    int             n;

    initial begin
        in_valid  = 1'b0;
        mdata_in  = '0;
        edata_in  = '0;
        out_ready = 1'b1;
        rst       = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", OW'(out_valid), OW'(0));
        check("reset_out_data", {mdata_out, edata_out}, OW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", OW'(in_ready), OW'(1));
        check("post_reset_out_valid", OW'(out_valid), OW'(0));

        // Directed blocks, unstalled, one at a time with latency checked.
        lat_check = 1'b1;
        @(posedge clk);
        #1;
        send({16'h0000, 16'hFF00, 16'h0080, 16'h0100}, 5'd15, {8'h00, 8'hC0, 8'h20, 8'h40, 4'h1});
        repeat (3) @(posedge clk);
        #1;
        send({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 5'd20, OW'(0));
        repeat (3) @(posedge clk);
        #1;
        send({16'h0000, 16'h0000, 16'h0000, 16'h0001}, 5'd0, OW'(0));
        repeat (3) @(posedge clk);
        #1;
        send({16'h0001, 16'h0000, 16'hC000, 16'h4000}, 5'd31, {8'h7F, 8'h00, 8'h80, 8'h7F, 4'hF});
        repeat (3) @(posedge clk);
        #1;
        lat_check = 1'b0;

        // Six blocks back-to-back, output stalled for five cycles at the start.
        out_ready = 1'b0;
        base      = out_count;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    for (int j = 0; j < BS; j++) m[j*MWI +: MWI] = rand_mant();
                    e = EWI'($urandom_range(0, 31));
                    send(m, e, ref_model(m, e));
                end
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_low", OW'(in_ready), OW'(0));
                check("stall_out_valid_high", OW'(out_valid), OW'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("stream_full_throughput", OW'(out_count - base), OW'(6));

        // Reset with two blocks in flight: they must vanish.
        out_ready = 1'b0;
        send({16'h1234, 16'h0567, 16'hF00F, 16'h0042}, 5'd18, OW'(0));
        send({16'h7000, 16'h0001, 16'h8001, 16'h0F00}, 5'd25, OW'(0));
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", OW'(out_valid), OW'(0));
        check("midreset_out_data", {mdata_out, edata_out}, OW'(0));
        check("midreset_in_ready", OW'(in_ready), OW'(1));
        out_ready = 1'b1;
        lat_check = 1'b1;
        @(posedge clk);
        #1;
        m = {16'h0003, 16'hFFF0, 16'h0020, 16'h0008};
        send(m, 5'd21, ref_model(m, 5'd21));
        repeat (4) @(posedge clk);
        #1;
        lat_check = 1'b0;

        // Randomised traffic with random gaps and random back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 9) == 0) begin
                m = '0;
            end else begin
                for (int j = 0; j < BS; j++) m[j*MWI +: MWI] = rand_mant();
            end
            e = EWI'($urandom_range(0, 31));
            send(m, e, ref_model(m, e));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", OW'(exp_q.size()), OW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
